alu_issue_ctrl: RTL

ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

---
 rtl/alu_pkg.sv | 65 ++++++
 rtl/alu_decode.sv | 110 +++++++++++
 rtl/alu_issue_ctrl.sv | 130 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: 5-bit operation codes, RV32 opcode/funct fields and the
// issue-controller state encoding.
package alu_pkg;

  typedef enum logic [4:0] {
    AluAdd  = 5'd0,
    AluSub  = 5'd1,
    AluSll  = 5'd2,
    AluSlt  = 5'd3,
    AluXor  = 5'd4,
    AluSrl  = 5'd5,
    AluSra  = 5'd6,
    AluOr   = 5'd7,
    AluAnd  = 5'd8,
    AluMul  = 5'd9,
    AluDiv  = 5'd10,
    AluAddi = 5'd11,
    AluSlti = 5'd12,
    AluXori = 5'd13,
    AluOri  = 5'd14,
    AluAndi = 5'd15,
    AluSlli = 5'd16,
    AluSrli = 5'd17,
    AluSrai = 5'd18,
    AluLui  = 5'd19,
    AluAuip = 5'd20,
    AluNot  = 5'd21,
    AluNoti = 5'd22,
    AluSubi = 5'd23,
    AluMuli = 5'd24,
    AluDivi = 5'd25,
    AluNull = 5'd31
  } alu_op_e;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StHold  = 2'd1,
    StValid = 2'd2
  } issue_state_e;

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] OpcOpImm = 7'b0010011;
  localparam logic [6:0] OpcLui   = 7'b0110111;
  localparam logic [6:0] OpcAuipc = 7'b0010111;

  localparam logic [6:0] F7Base   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;
  localparam logic [6:0] F7MulDiv = 7'b0000001;

  localparam logic [2:0] F3AddSub = 3'b000;
  localparam logic [2:0] F3Sll    = 3'b001;
  localparam logic [2:0] F3Slt    = 3'b010;
  localparam logic [2:0] F3Xor    = 3'b100;
  localparam logic [2:0] F3Sr     = 3'b101;
  localparam logic [2:0] F3Or     = 3'b110;
  localparam logic [2:0] F3And    = 3'b111;
  localparam logic [2:0] F3Mul    = 3'b000;
  localparam logic [2:0] F3Div    = 3'b100;

  // Extra cycles an op is held before its result is presented (0 = single cycle).
  function automatic logic [3:0] hold_len(input int unsigned cycles);
    return 4'(cycles - 1);
  endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32 field decode into ALU control code, operands, illegal flag and
// the number of extra hold cycles for multi-cycle ops.
module alu_decode
  import alu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  input  logic [31:0] i_imm,
  input  logic [31:0] i_pc,
  output alu_op_e     o_ctrl,
  output logic [31:0] o_a,
  output logic [31:0] o_b,
  output logic        o_illegal,
  output logic [3:0]  o_hold_len
);

  localparam logic [3:0] MulLen = hold_len(MUL_CYCLES);
  localparam logic [3:0] DivLen = hold_len(DIV_CYCLES);

  alu_op_e     w_op;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_ok;
  logic [3:0]  w_len;

  always_comb begin
    w_op  = AluNull;
    w_a   = '0;
    w_b   = '0;
    w_ok  = 1'b0;
    w_len = '0;
    case (i_opcode)
      OpcOp: begin
        w_a  = i_rs1;
        w_b  = i_rs2;
        w_ok = 1'b1;
        if (i_funct7 == F7MulDiv) begin
          case (i_funct3)
            F3Mul: begin w_op = AluMul; w_len = MulLen; end
            F3Div: begin w_op = AluDiv; w_len = DivLen; end
            default: w_ok = 1'b0;
          endcase
        end else if (i_funct7 == F7Base || i_funct7 == F7Alt) begin
          // The alternate funct7 is only meaningful for SUB and SRA.
          case ({i_funct7[5], i_funct3})
            {1'b0, F3AddSub}: w_op = AluAdd;
            {1'b1, F3AddSub}: w_op = AluSub;
            {1'b0, F3Sll}:    w_op = AluSll;
            {1'b0, F3Slt}:    w_op = AluSlt;
            {1'b0, F3Xor}:    w_op = AluXor;
            {1'b0, F3Sr}:     w_op = AluSrl;
            {1'b1, F3Sr}:     w_op = AluSra;
            {1'b0, F3Or}:     w_op = AluOr;
            {1'b0, F3And}:    w_op = AluAnd;
            default:          w_ok = 1'b0;
          endcase
        end else begin
          w_ok = 1'b0;
        end
      end
      OpcOpImm: begin
        w_a  = i_rs1;
        w_b  = i_imm;
        w_ok = 1'b1;
        case (i_funct3)
          F3AddSub: w_op = AluAddi;
          F3Slt:    w_op = AluSlti;
          F3Xor:    w_op = AluXori;
          F3Or:     w_op = AluOri;
          F3And:    w_op = AluAndi;
          F3Sll: begin
            w_op = AluSlli;
            w_b  = {27'b0, i_imm[4:0]};
          end
          F3Sr: begin
            w_op = i_funct7[5] ? AluSrai : AluSrli;
            w_b  = {27'b0, i_imm[4:0]};
          end
          default: w_ok = 1'b0;
        endcase
      end
      OpcLui: begin
        w_op = AluLui;
        w_a  = i_imm;
        w_b  = 32'd12;
        w_ok = 1'b1;
      end
      OpcAuipc: begin
        w_op = AluAuip;
        w_a  = i_pc;
        w_b  = i_imm << 12;
        w_ok = 1'b1;
      end
      default: w_ok = 1'b0;
    endcase
  end

  assign o_ctrl     = w_ok ? w_op  : AluNull;
  assign o_a        = w_ok ? w_a   : '0;
  assign o_b        = w_ok ? w_b   : '0;
  assign o_illegal  = ~w_ok;
  assign o_hold_len = w_ok ? w_len : '0;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Single-entry ALU issue stage: decodes an accepted instruction, holds multi-cycle
// ops for a fixed count, then presents the settled operands to the consumer.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [31:0] in_rs1_val,
  input  logic [31:0] in_rs2_val,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_pc,
  output logic [4:0]  alu_control,
  output logic [31:0] alu_input_A,
  output logic [31:0] alu_input_B,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic        illegal
);

  issue_state_e r_state, w_state_d;
  logic [3:0]   r_cnt, w_cnt_d;
  alu_op_e      r_ctrl, w_ctrl_d;
  logic [31:0]  r_a, w_a_d;
  logic [31:0]  r_b, w_b_d;
  logic         r_ill, w_ill_d;

  alu_op_e     w_dec_ctrl;
  logic [31:0] w_dec_a;
  logic [31:0] w_dec_b;
  logic        w_dec_ill;
  logic [3:0]  w_dec_len;
  logic        w_in_ready;
  logic        w_accept;

  alu_decode #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES)
  ) u_decode (
    .i_opcode  (in_opcode),
    .i_funct3  (in_funct3),
    .i_funct7  (in_funct7),
    .i_rs1     (in_rs1_val),
    .i_rs2     (in_rs2_val),
    .i_imm     (in_imm),
    .i_pc      (in_pc),
    .o_ctrl    (w_dec_ctrl),
    .o_a       (w_dec_a),
    .o_b       (w_dec_b),
    .o_illegal (w_dec_ill),
    .o_hold_len(w_dec_len)
  );

  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      StEmpty: w_in_ready = 1'b1;
      StValid: w_in_ready = ex_ready;
      default: w_in_ready = 1'b0;
    endcase
  end

  assign w_accept = in_valid & w_in_ready;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_ctrl_d  = r_ctrl;
    w_a_d     = r_a;
    w_b_d     = r_b;
    w_ill_d   = r_ill;
    // Going empty always clears the output register so EMPTY presents a NULL op.
    if (flush || (r_state == StValid && ex_ready && !w_accept) ||
        (r_state != StEmpty && r_state != StHold && r_state != StValid)) begin
      w_state_d = StEmpty;
      w_cnt_d   = '0;
      w_ctrl_d  = AluNull;
      w_a_d     = '0;
      w_b_d     = '0;
      w_ill_d   = 1'b0;
    end else if (w_accept) begin
      w_state_d = (w_dec_len == 4'd0) ? StValid : StHold;
      w_cnt_d   = w_dec_len;
      w_ctrl_d  = w_dec_ctrl;
      w_a_d     = w_dec_a;
      w_b_d     = w_dec_b;
      w_ill_d   = w_dec_ill;
    end else if (r_state == StHold) begin
      w_cnt_d = r_cnt - 4'd1;
      if (r_cnt <= 4'd1) begin
        w_state_d = StValid;
        w_cnt_d   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StEmpty;
      r_cnt   <= '0;
      r_ctrl  <= AluNull;
      r_a     <= '0;
      r_b     <= '0;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_ctrl  <= w_ctrl_d;
      r_a     <= w_a_d;
      r_b     <= w_b_d;
      r_ill   <= w_ill_d;
    end
  end

  assign in_ready    = w_in_ready;
  assign ex_valid    = (r_state == StValid);
  assign alu_control = r_ctrl;
  assign alu_input_A = r_a;
  assign alu_input_B = r_b;
  assign illegal     = r_ill;

endmodule
